// File: rtl/wram_arbiter_pkg.sv
// Shared definitions for the 68k work-RAM arbiter: FSM states, port IDs,
// default strobe lengths and the grant-selection rule.
`timescale 1ns/1ps
package wram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int DEF_RD_CYCLES = 3;
    localparam int DEF_WR_CYCLES = 2;
    localparam int DEF_AW        = 15;

    // On a tie the port that did not win last time gets the RAM, so B is never starved.
    function automatic logic pick_winner(input logic a_req, input logic b_req, input logic last_grant);
        logic winner;
        if (a_req && b_req) begin
            winner = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (a_req) begin
            winner = PORT_A;
        end else begin
            winner = PORT_B;
        end
        return winner;
    endfunction

endpackage

// File: rtl/wram_port_mux.sv
// Grant select between the two requesters; latches the winning request
// fields and the last granted port when the FSM accepts a request.
`timescale 1ns/1ps
module wram_port_mux
    import wram_arbiter_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_grant,
    input  logic          i_a_req,
    input  logic          i_a_we,
    input  logic [AW-1:0] i_a_addr,
    input  logic [1:0]    i_a_be,
    input  logic [15:0]   i_a_wdata,
    input  logic          i_b_req,
    input  logic          i_b_we,
    input  logic [AW-1:0] i_b_addr,
    input  logic [1:0]    i_b_be,
    input  logic [15:0]   i_b_wdata,
    output logic          o_any_req,
    output logic          o_sel_we,
    output logic [1:0]    o_sel_be,
    output logic          o_port,
    output logic          o_we,
    output logic [1:0]    o_be,
    output logic [AW-1:0] o_addr,
    output logic [15:0]   o_wdata
);

    logic          r_last_grant;
    logic          r_port;
    logic          r_we;
    logic [1:0]    r_be;
    logic [AW-1:0] r_addr;
    logic [15:0]   r_wdata;

    logic          w_winner;
    logic          w_sel_we;
    logic [1:0]    w_sel_be;
    logic [AW-1:0] w_sel_addr;
    logic [15:0]   w_sel_wdata;

    assign w_winner = pick_winner(i_a_req, i_b_req, r_last_grant);

    always_comb begin
        w_sel_we    = i_a_we;
        w_sel_be    = i_a_be;
        w_sel_addr  = i_a_addr;
        w_sel_wdata = i_a_wdata;
        if (w_winner == PORT_B) begin
            w_sel_we    = i_b_we;
            w_sel_be    = i_b_be;
            w_sel_addr  = i_b_addr;
            w_sel_wdata = i_b_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_last_grant <= PORT_B;
            r_port       <= PORT_A;
            r_we         <= 1'b0;
            r_be         <= 2'b00;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else if (i_grant) begin
            r_last_grant <= w_winner;
            r_port       <= w_winner;
            r_we         <= w_sel_we;
            r_be         <= w_sel_be;
            r_addr       <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
        end
    end

    assign o_any_req = i_a_req | i_b_req;
    assign o_sel_we  = w_sel_we;
    assign o_sel_be  = w_sel_be;
    assign o_port    = r_port;
    assign o_we      = r_we;
    assign o_be      = r_be;
    assign o_addr    = r_addr;
    assign o_wdata   = r_wdata;

endmodule

// File: rtl/wram_arbiter.sv
// Two-port sequencer for the 68k work RAM: arbitrates requests and produces
// registered nCE/nOE/nWE strobe sequences for two byte-lane async SRAMs.
`timescale 1ns/1ps
module wram_arbiter
    import wram_arbiter_pkg::*;
#(
    parameter int RD_CYCLES = DEF_RD_CYCLES,
    parameter int WR_CYCLES = DEF_WR_CYCLES,
    parameter int AW        = DEF_AW
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_a_req,
    input  logic          i_a_we,
    input  logic [AW-1:0] i_a_addr,
    input  logic [1:0]    i_a_be,
    input  logic [15:0]   i_a_wdata,
    output logic          o_a_ack,
    output logic [15:0]   o_a_rdata,
    input  logic          i_b_req,
    input  logic          i_b_we,
    input  logic [AW-1:0] i_b_addr,
    input  logic [1:0]    i_b_be,
    input  logic [15:0]   i_b_wdata,
    output logic          o_b_ack,
    output logic [15:0]   o_b_rdata,
    output logic [AW-1:0] o_ram_addr,
    output logic [15:0]   o_ram_dout,
    output logic          o_ram_doe,
    input  logic [15:0]   i_ram_din,
    output logic          o_nce_h,
    output logic          o_nce_l,
    output logic          o_noe,
    output logic          o_nwe
);

    localparam logic [3:0] RD_CNT = 4'(RD_CYCLES);
    localparam logic [3:0] WR_CNT = 4'(WR_CYCLES);

    state_t        r_state, w_state_next;
    logic [3:0]    r_cnt, w_cnt_next;
    logic          r_nce_h, w_nce_h_next;
    logic          r_nce_l, w_nce_l_next;
    logic          r_noe, w_noe_next;
    logic          r_nwe, w_nwe_next;
    logic          r_doe, w_doe_next;
    logic          r_a_ack, w_a_ack_next;
    logic          r_b_ack, w_b_ack_next;
    logic [15:0]   r_a_rdata, w_a_rdata_next;
    logic [15:0]   r_b_rdata, w_b_rdata_next;

    logic          w_grant;
    logic          w_any_req;
    logic          w_sel_we;
    logic [1:0]    w_sel_be;
    logic          w_lat_port;
    logic          w_lat_we;
    logic [1:0]    w_lat_be;
    logic [AW-1:0] w_lat_addr;
    logic [15:0]   w_lat_wdata;

    wram_port_mux #(.AW(AW)) u_port_mux (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_grant   (w_grant),
        .i_a_req   (i_a_req),
        .i_a_we    (i_a_we),
        .i_a_addr  (i_a_addr),
        .i_a_be    (i_a_be),
        .i_a_wdata (i_a_wdata),
        .i_b_req   (i_b_req),
        .i_b_we    (i_b_we),
        .i_b_addr  (i_b_addr),
        .i_b_be    (i_b_be),
        .i_b_wdata (i_b_wdata),
        .o_any_req (w_any_req),
        .o_sel_we  (w_sel_we),
        .o_sel_be  (w_sel_be),
        .o_port    (w_lat_port),
        .o_we      (w_lat_we),
        .o_be      (w_lat_be),
        .o_addr    (w_lat_addr),
        .o_wdata   (w_lat_wdata)
    );

    // Every output is a flop: next values are computed here and registered below.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_nce_h_next   = r_nce_h;
        w_nce_l_next   = r_nce_l;
        w_noe_next     = r_noe;
        w_nwe_next     = r_nwe;
        w_doe_next     = r_doe;
        w_a_ack_next   = 1'b0;
        w_b_ack_next   = 1'b0;
        w_a_rdata_next = r_a_rdata;
        w_b_rdata_next = r_b_rdata;
        w_grant        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_grant      = 1'b1;
                    w_state_next = ST_SETUP;
                    w_nce_h_next = ~w_sel_be[1];
                    w_nce_l_next = ~w_sel_be[0];
                    w_doe_next   = w_sel_we & (|w_sel_be);
                end
            end
            ST_SETUP: begin
                w_state_next = ST_STROBE;
                w_cnt_next   = w_lat_we ? WR_CNT : RD_CNT;
                // An empty byte mask runs the full timing with no strobe at all.
                if (|w_lat_be) begin
                    w_noe_next = w_lat_we;
                    w_nwe_next = ~w_lat_we;
                end
            end
            ST_STROBE: begin
                if (r_cnt <= 4'd1) begin
                    w_state_next = ST_RECOVER;
                    w_noe_next   = 1'b1;
                    w_nwe_next   = 1'b1;
                    if (w_lat_port == PORT_A) begin
                        w_a_ack_next = 1'b1;
                    end else begin
                        w_b_ack_next = 1'b1;
                    end
                    if (!w_lat_we && (|w_lat_be)) begin
                        if (w_lat_port == PORT_A) begin
                            w_a_rdata_next = i_ram_din;
                        end else begin
                            w_b_rdata_next = i_ram_din;
                        end
                    end
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_RECOVER: begin
                w_state_next = ST_IDLE;
                w_nce_h_next = 1'b1;
                w_nce_l_next = 1'b1;
                w_doe_next   = 1'b0;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_nce_h   <= 1'b1;
            r_nce_l   <= 1'b1;
            r_noe     <= 1'b1;
            r_nwe     <= 1'b1;
            r_doe     <= 1'b0;
            r_a_ack   <= 1'b0;
            r_b_ack   <= 1'b0;
            r_a_rdata <= 16'h0000;
            r_b_rdata <= 16'h0000;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_nce_h   <= w_nce_h_next;
            r_nce_l   <= w_nce_l_next;
            r_noe     <= w_noe_next;
            r_nwe     <= w_nwe_next;
            r_doe     <= w_doe_next;
            r_a_ack   <= w_a_ack_next;
            r_b_ack   <= w_b_ack_next;
            r_a_rdata <= w_a_rdata_next;
            r_b_rdata <= w_b_rdata_next;
        end
    end

    assign o_a_ack    = r_a_ack;
    assign o_b_ack    = r_b_ack;
    assign o_a_rdata  = r_a_rdata;
    assign o_b_rdata  = r_b_rdata;
    assign o_ram_addr = w_lat_addr;
    assign o_ram_dout = w_lat_wdata;
    assign o_ram_doe  = r_doe;
    assign o_nce_h    = r_nce_h;
    assign o_nce_l    = r_nce_l;
    assign o_noe      = r_noe;
    assign o_nwe      = r_nwe;

endmodule

// File: tb/tb_wram_arbiter.sv
// Bench for wram_arbiter: directed vector table, multi-cycle corner sequences,
// and random two-port traffic against a word-level memory model.
`timescale 1ns/1ps
module tb_wram_arbiter;
    import wram_arbiter_pkg::*;

    localparam int AW = 15;
    localparam int RD = 3;
    localparam int WR = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          aReq, aWe, bReq, bWe;
    logic [AW-1:0] aAddr, bAddr;
    logic [1:0]    aBe, bBe;
    logic [15:0]   aWdata, bWdata;
    logic          aAck, bAck;
    logic [15:0]   aRdata, bRdata;
    logic [AW-1:0] ramAddr;
    logic [15:0]   ramDout, ramDin;
    logic          ramDoe, nceH, nceL, noe, nwe;

    wram_arbiter #(.RD_CYCLES(RD), .WR_CYCLES(WR), .AW(AW)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_a_req(aReq), .i_a_we(aWe), .i_a_addr(aAddr), .i_a_be(aBe), .i_a_wdata(aWdata),
        .o_a_ack(aAck), .o_a_rdata(aRdata),
        .i_b_req(bReq), .i_b_we(bWe), .i_b_addr(bAddr), .i_b_be(bBe), .i_b_wdata(bWdata),
        .o_b_ack(bAck), .o_b_rdata(bRdata),
        .o_ram_addr(ramAddr), .o_ram_dout(ramDout), .o_ram_doe(ramDoe), .i_ram_din(ramDin),
        .o_nce_h(nceH), .o_nce_l(nceL), .o_noe(noe), .o_nwe(nwe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    always @(posedge clk) cycle++;

    // Board SRAM pair; a deselected lane reads as 0x00 on the bench bus.
    logic [7:0] sramH [0:(1<<AW)-1];
    logic [7:0] sramL [0:(1<<AW)-1];
    always @(negedge clk) begin
        if (!nwe && ramDoe) begin
            if (!nceH) sramH[ramAddr] = ramDout[15:8];
            if (!nceL) sramL[ramAddr] = ramDout[7:0];
        end
    end
    always_comb begin
        ramDin = 16'h0000;
        if (!nceH && !noe) ramDin[15:8] = sramH[ramAddr];
        if (!nceL && !noe) ramDin[7:0]  = sramL[ramAddr];
    end

    // Reference model: word memory and each port's expected read-data register.
    logic [15:0] refMem [0:(1<<AW)-1];
    logic [15:0] expRd [2];

    int ackCnt [2];
    int ackLog [$];
    bit sawNceH;
    always @(negedge clk) begin
        if (aAck) begin ackCnt[0]++; ackLog.push_back(0); end
        if (bAck) begin ackCnt[1]++; ackLog.push_back(1); end
        if (!nceH) sawNceH = 1'b1;
    end

    always @(negedge clk) begin
        checks++;
        if (!noe && !nwe) begin
            failures++;
            $display("[TB] FAIL noe_nwe_overlap ERROR at t=%0t: nOE=%b nWE=%b, required never both 0", $time, noe, nwe);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One request/ack handshake; call at a negedge. Updates the reference model on ACK.
    task automatic applyStimulus(input logic port, input logic we, input logic [AW-1:0] addr,
                                 input logic [1:0] be, input logic [15:0] wdata, input bit keep,
                                 output int lat, output int strobes, output logic [15:0] rdata);
        bit done;
        logic [15:0] old;
        done = 1'b0;
        lat = 0;
        strobes = 0;
        rdata = 16'h0000;
        if (port == PORT_A) begin
            aWe = we; aAddr = addr; aBe = be; aWdata = wdata; aReq = 1'b1;
        end else begin
            bWe = we; bAddr = addr; bBe = be; bWdata = wdata; bReq = 1'b1;
        end
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            if ((we && !nwe) || (!we && !noe)) strobes++;
            done = (port == PORT_A) ? aAck : bAck;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("[TB] FAIL ack_timeout port=%0d actual=no_ack required=ack_within_100_clks", port);
        end else begin
            rdata = (port == PORT_A) ? aRdata : bRdata;
            old = refMem[addr];
            if (we) begin
                refMem[addr] = {be[1] ? wdata[15:8] : old[15:8], be[0] ? wdata[7:0] : old[7:0]};
            end else if (be != 2'b00) begin
                expRd[port] = {be[1] ? old[15:8] : 8'h00, be[0] ? old[7:0] : 8'h00};
            end
        end
        if (!keep) begin
            if (port == PORT_A) aReq = 1'b0; else bReq = 1'b0;
        end
    endtask

    task automatic randomPort(input logic port, input int endCycle, output int issued);
        bit kept;
        logic we;
        logic [AW-1:0] addr;
        logic [1:0] be;
        logic [15:0] wd, rd;
        bit keep;
        int l, s;
        kept = 1'b0;
        issued = 0;
        while (cycle < endCycle) begin
            if (!kept) repeat ($urandom_range(0, 3)) @(negedge clk);
            we   = 1'($urandom_range(0, 1));
            addr = 15'h0100 + 15'($urandom_range(0, 15));
            be   = 2'($urandom_range(0, 3));
            wd   = 16'($urandom);
            keep = ($urandom_range(0, 3) == 0);
            applyStimulus(port, we, addr, be, wd, keep, l, s, rd);
            issued++;
            if (!we) checkOutput($sformatf("rand_rd_p%0d_a%0h_be%0b", port, addr, be), rd, expRd[port]);
            kept = keep;
        end
        if (port == PORT_A) aReq = 1'b0; else bReq = 1'b0;
    endtask

    typedef struct {
        logic        port;
        logic        we;
        logic [14:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
        logic [15:0] expRdata;
        int          expLat;
        int          expStrobes;
        bit          expNceHHigh;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat, str, issuedA, issuedB, bAcks0, aAcks0, endCycle, n;
        logic [15:0] rd;

        aReq = 0; aWe = 0; aAddr = '0; aBe = 0; aWdata = 0;
        bReq = 0; bWe = 0; bAddr = '0; bBe = 0; bWdata = 0;
        for (int i = 0; i < (1 << AW); i++) begin
            sramH[i] = 8'h00; sramL[i] = 8'h00; refMem[i] = 16'h0000;
        end
        expRd[0] = 16'h0000;
        expRd[1] = 16'h0000;
        ackCnt[0] = 0;
        ackCnt[1] = 0;

        vecs[0] = '{PORT_A, 1'b1, 15'h0123, 2'b11, 16'hBEEF, 16'h0000, 4, 2, 1'b0};
        vecs[1] = '{PORT_A, 1'b0, 15'h0123, 2'b11, 16'h0000, 16'hBEEF, 5, 3, 1'b0};
        vecs[2] = '{PORT_A, 1'b1, 15'h0010, 2'b11, 16'hAA55, 16'h0000, 4, 2, 1'b0};
        vecs[3] = '{PORT_A, 1'b1, 15'h0010, 2'b01, 16'h1234, 16'h0000, 4, 2, 1'b1};
        vecs[4] = '{PORT_A, 1'b0, 15'h0010, 2'b11, 16'h0000, 16'hAA34, 5, 3, 1'b0};
        vecs[5] = '{PORT_A, 1'b0, 15'h0300, 2'b00, 16'h0000, 16'hAA34, 5, 0, 1'b1};
        vecs[6] = '{PORT_B, 1'b1, 15'h0200, 2'b10, 16'hC35A, 16'h0000, 4, 2, 1'b0};
        vecs[7] = '{PORT_B, 1'b0, 15'h0200, 2'b11, 16'h0000, 16'hC300, 5, 3, 1'b0};
        vecs[8] = '{PORT_B, 1'b0, 15'h0200, 2'b10, 16'h0000, 16'hC300, 5, 3, 1'b0};

        repeat (2) @(negedge clk);
        checkOutput("rst_nce_h", nceH, 1);
        checkOutput("rst_nce_l", nceL, 1);
        checkOutput("rst_noe", noe, 1);
        checkOutput("rst_nwe", nwe, 1);
        checkOutput("rst_doe", ramDoe, 0);
        checkOutput("rst_a_ack", aAck, 0);
        checkOutput("rst_b_ack", bAck, 0);
        checkOutput("rst_ram_addr", ramAddr, 0);
        checkOutput("rst_ram_dout", ramDout, 0);
        checkOutput("rst_a_rdata", aRdata, 0);
        checkOutput("rst_b_rdata", bRdata, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed vector table");
        for (int i = 0; i < 9; i++) begin
            repeat (2) @(negedge clk);
            sawNceH = 1'b0;
            applyStimulus(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, 1'b0, lat, str, rd);
            checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].expLat);
            checkOutput($sformatf("vec%0d_strobe_clks", i), str, vecs[i].expStrobes);
            if (!vecs[i].we) checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].expRdata);
            if (vecs[i].expNceHHigh) checkOutput($sformatf("vec%0d_nce_h_low_seen", i), sawNceH, 0);
        end

        $display("[TB] both ports requesting continuously");
        repeat (2) @(negedge clk);
        ackLog.delete();
        bAcks0 = ackCnt[1];
        fork
            begin
                int l, s; logic [15:0] r;
                for (int i = 0; i < 3; i++)
                    applyStimulus(PORT_A, 1'b1, 15'h0300 + 15'(i), 2'b11, 16'hA000 + 16'(i), (i < 2), l, s, r);
            end
            begin
                int l, s; logic [15:0] r;
                for (int i = 0; i < 3; i++)
                    applyStimulus(PORT_B, 1'b1, 15'h0310 + 15'(i), 2'b11, 16'hB000 + 16'(i), (i < 2), l, s, r);
            end
        join
        @(negedge clk);
        checkOutput("arb_grant_count", ackLog.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < ackLog.size()) checkOutput($sformatf("arb_grant%0d_port", i), ackLog[i], i % 2);
        checkOutput("arb_b_ack_count", ackCnt[1] - bAcks0, 3);

        $display("[TB] port B init clear with REQ held");
        repeat (2) @(negedge clk);
        applyStimulus(PORT_A, 1'b1, 15'h0005, 2'b11, 16'h7777, 1'b0, lat, str, rd);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(PORT_B, 1'b1, 15'(i), 2'b11, 16'h0000, (i < 15), lat, str, rd);
            checkOutput($sformatf("clear%0d_ack_spacing", i), lat, (i == 0) ? 4 : 5);
        end
        repeat (2) @(negedge clk);
        applyStimulus(PORT_A, 1'b0, 15'h0005, 2'b11, 16'h0000, 1'b0, lat, str, rd);
        checkOutput("clear_readback_0005", rd, 16'h0000);

        $display("[TB] reset during write strobe");
        repeat (2) @(negedge clk);
        aWe = 1'b1; aAddr = 15'h7000; aBe = 2'b11; aWdata = 16'h5A5A; aReq = 1'b1;
        n = 0;
        while (nwe && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rst_mid_reached_strobe", nwe, 0);
        aAcks0 = ackCnt[0];
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_mid_nwe", nwe, 1);
        checkOutput("rst_mid_noe", noe, 1);
        checkOutput("rst_mid_nce_h", nceH, 1);
        checkOutput("rst_mid_nce_l", nceL, 1);
        checkOutput("rst_mid_doe", ramDoe, 0);
        aReq = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        expRd[0] = 16'h0000;
        expRd[1] = 16'h0000;
        repeat (2) @(negedge clk);
        checkOutput("rst_mid_no_ack", ackCnt[0] - aAcks0, 0);
        checkOutput("rst_mid_a_rdata_cleared", aRdata, 0);
        applyStimulus(PORT_A, 1'b0, 15'h0123, 2'b11, 16'h0000, 1'b0, lat, str, rd);
        checkOutput("post_rst_read_latency", lat, 5);
        checkOutput("post_rst_read_data", rd, 16'hBEEF);

        $display("[TB] random two-port traffic");
        repeat (2) @(negedge clk);
        aAcks0 = ackCnt[0];
        bAcks0 = ackCnt[1];
        endCycle = cycle + 10000;
        fork
            randomPort(PORT_A, endCycle, issuedA);
            randomPort(PORT_B, endCycle, issuedB);
        join
        repeat (4) @(negedge clk);
        checkOutput("rand_a_one_ack_per_req", ackCnt[0] - aAcks0, issuedA);
        checkOutput("rand_b_one_ack_per_req", ackCnt[1] - bAcks0, issuedB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
